pkt_router_param: RTL and testbench
===================================

Name: pkt_router_param

Overview:
Parametrised N-channel packet router, the successor to the fixed 3-channel, depth-4 router. One byte-serial input port feeds NCH output FIFOs with configurable depth and width. Adds input back-pressure, invalid-address drop, truncation detection, per-channel timeout flush and sticky error counters. Sits between the pin-mux top level and per-channel readers.

Parameters:
DW, 8, data width in bits (>=4); header[1:0]=dest, header[DW-1:2]=payload length
NCH, 3, number of output channels (1..3); dest >= NCH is invalid
DEPTH, 16, FIFO depth per channel (power of 2, >=4)
TIMEOUT, 30, idle-read cycles before a non-empty channel is flushed (>=2)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
pkt_valid  in  1  input byte valid; held high for the whole packet
din  in  DW  header, payload bytes, then parity byte
busy  out  1  input stall; a byte is accepted only when pkt_valid && !busy
rd_en  in  NCH  per-channel pop request
dout  out  NCH*DW  per-channel FIFO head, first-word-fall-through; channel i at [i*DW +: DW]
vldout  out  NCH  channel i FIFO non-empty
err_par  out  1  one-cycle pulse: parity mismatch
err_trunc  out  1  one-cycle pulse: pkt_valid dropped mid-packet
flush  out  NCH  one-cycle pulse: channel i flushed by timeout
err_cnt  out  8  saturating count of err_par + err_trunc events

Behaviour:
- Reset (resetn=0 at posedge clk): FSM=IDLE, all FIFOs empty, pointers/counters/timers 0; busy=0, vldout=0, dout=0, err_par=0, err_trunc=0, flush=0, err_cnt=0. Reset mid-packet discards the partial packet, including bytes already written.
- Handshake: accepted byte = pkt_valid && !busy at posedge. busy=1 when FSM is in CHECK, or when the current destination FIFO is full (registered count==DEPTH) and the FSM is in HDR_WAIT, PAYLOAD or PARITY.
- FSM states:
  - IDLE: accepted byte is the header. Latch dest and len; parity_acc=header. If dest<NCH, write the header to FIFO[dest] and go to PAYLOAD (PARITY if len==0). Otherwise go to DROP.
  - PAYLOAD: each accepted byte is written and XORed into parity_acc; len decrements. On the last payload byte, go to PARITY.
  - PARITY: accepted byte is written, latched as recv_par, then go to CHECK.
  - CHECK: one cycle, busy=1. err_par pulses if parity_acc != recv_par. Return to IDLE.
  - DROP: consume len payload bytes plus the parity byte without writing, busy=0. Return to IDLE. No error is raised.
- If header arrives while FIFO[dest] is full: HDR_WAIT is implicit. busy=1 and the header is not accepted until space exists.
- Truncation: pkt_valid=0 in PAYLOAD, PARITY or DROP -> err_trunc pulses, go to IDLE. Bytes already written stay in the FIFO.
- FIFO: write and pop in the same cycle on a non-full, non-empty FIFO leaves count unchanged. Pop on empty is ignored. Pointers wrap modulo DEPTH. dout shows mem[rd_ptr] when non-empty, 0 when empty. Write-to-read latency: vldout rises the cycle after the write.
- Timeout: per-channel counter increments each cycle while vldout[i]=1 and rd_en[i]=0. It clears on any pop or when empty. When it reaches TIMEOUT, channel i is flushed on the next edge (count=0, rd_ptr=wr_ptr) and flush[i] pulses. If the FSM is writing to channel i that cycle, the write wins over the flush for that byte; the flush still empties all prior contents.
- err_cnt increments by 1 per event. If err_par and err_trunc occur in the same cycle it increments by 2. It saturates at 255.

Decomposition:
- Package router_pkg holds: header field positions (ADDR_LSB=0, ADDR_W=2, LEN_LSB=2), FSM state enum (IDLE, PAYLOAD, PARITY, CHECK, DROP) and the clog2 helper.
- Sub-module router_fifo_param (DW, DEPTH): instantiated NCH times via generate. Provides push, pop, flush, dout, count, full and empty.

Test Plan:
- Header 8'h0C (dest0, len3), payload 11,22,33, parity 0C^11^22^33=8'h0C -> FIFO0 holds 5 bytes, vldout=001, err_par=0; popping returns 0C,11,22,33,0C.
- Same packet with parity 8'hFF -> err_par pulses once in CHECK, err_cnt=1, all 5 bytes still stored.
- DEPTH=4, header 8'h15 (dest1, len5), no reads -> busy rises after 4 bytes. Pulse rd_en[1] once -> exactly one more byte is accepted.
- Header 8'h07 (dest3, len1) then 2 bytes -> nothing written, vldout=000, no errors, next packet routes normally.
- Header 8'h0E (dest2, len3), 1 payload byte, then pkt_valid=0 -> err_trunc pulses, FIFO2 holds 2 bytes, FSM returns to IDLE.
- Write 1 byte to ch0, hold rd_en=0 for TIMEOUT cycles -> flush[0] pulses, vldout[0]=0. Assert resetn=0 mid-packet -> all outputs return to their reset values.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the parametrised packet router: header field layout,
// FSM state encoding and a constant-evaluable clog2 helper.
package router_pkg;

  // Header layout: dest in the low bits, payload length above it.
  localparam int unsigned ADDR_LSB = 0;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned LEN_LSB  = 2;

  // Input FSM states. A header waiting on a full FIFO stays in StIdle with busy high.
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StPayload = 3'd1;
  localparam logic [2:0] StParity  = 3'd2;
  localparam logic [2:0] StCheck   = 3'd3;
  localparam logic [2:0] StDrop    = 3'd4;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/router_fifo_param.sv
// Per-channel output FIFO: first-word-fall-through head, registered count,
// and a flush that empties prior contents while still keeping a same-cycle push.
module router_fifo_param
  import router_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [DW-1:0] o_dout,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  // A flush discards the head anyway, so a coincident pop has nothing to do.
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  // Storage array; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_flush) begin
        // Old write pointer becomes the head, so a same-cycle push survives.
        r_rd_ptr <= r_wr_ptr;
        r_count  <= CW'(w_do_push);
      end else begin
        if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_do_push, w_do_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: rtl/pkt_router_param.sv
// N-channel byte-serial packet router: parses header/payload/parity, steers
// bytes into per-channel FIFOs with back-pressure, drops bad addresses,
// detects truncation and parity errors, and flushes channels left unread.
module pkt_router_param
  import router_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned NCH     = 3,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_pkt_valid,
  input  logic [DW-1:0]     i_din,
  output logic              o_busy,
  input  logic [NCH-1:0]    i_rd_en,
  output logic [NCH*DW-1:0] o_dout,
  output logic [NCH-1:0]    o_vldout,
  output logic              o_err_par,
  output logic              o_err_trunc,
  output logic [NCH-1:0]    o_flush,
  output logic [7:0]        o_err_cnt
);

  localparam int unsigned LW = DW - LEN_LSB;
  localparam int unsigned CW = clog2(DEPTH) + 1;
  localparam int unsigned TW = clog2(TIMEOUT + 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_d;
  logic [ADDR_W-1:0] r_dest;
  logic [LW-1:0]     r_len;
  logic [DW-1:0]     r_par_acc;
  logic [DW-1:0]     r_recv_par;
  logic [7:0]        r_err_cnt;

  logic [ADDR_W-1:0] w_hdr_dest;
  logic [LW-1:0]     w_hdr_len;
  logic              w_hdr_ok;
  logic [ADDR_W-1:0] w_cur_dest;
  logic [NCH-1:0]    w_full;
  logic [NCH-1:0]    w_empty;
  logic [NCH-1:0]    w_push;
  logic [NCH-1:0]    w_flush;
  logic [3:0]        w_full_pad;
  logic              w_dst_full;
  logic              w_busy;
  logic              w_accept;
  logic              w_wr;
  logic              w_trunc;
  logic              w_par_err;
  logic [8:0]        w_err_sum;

  assign w_hdr_dest = i_din[ADDR_LSB +: ADDR_W];
  assign w_hdr_len  = i_din[LEN_LSB +: LW];
  assign w_hdr_ok   = (32'(w_hdr_dest) < NCH);
  // In StIdle the destination comes straight off the header byte on the bus.
  assign w_cur_dest = (r_state == StIdle) ? w_hdr_dest : r_dest;
  // Pad to the full 2-bit address space so an out-of-range dest indexes a zero.
  assign w_full_pad = 4'(w_full);
  assign w_dst_full = w_full_pad[w_cur_dest];
  assign w_accept   = i_pkt_valid && !w_busy;

  // Input stall: one bubble in StCheck, or the target FIFO is full.
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      StIdle:              w_busy = i_pkt_valid && w_hdr_ok && w_dst_full;
      StPayload, StParity: w_busy = w_dst_full;
      StCheck:             w_busy = 1'b1;
      default:             w_busy = 1'b0;
    endcase
  end

  // Next-state, FIFO write strobe and error pulse decode.
  always_comb begin
    w_state_d = r_state;
    w_wr      = 1'b0;
    w_trunc   = 1'b0;
    w_par_err = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_wr = w_hdr_ok;
          if (!w_hdr_ok)             w_state_d = StDrop;
          else if (w_hdr_len == '0)  w_state_d = StParity;
          else                       w_state_d = StPayload;
        end
      end
      StPayload: begin
        if (!i_pkt_valid) begin
          w_trunc   = 1'b1;
          w_state_d = StIdle;
        end else if (w_accept) begin
          w_wr = 1'b1;
          if (r_len == LW'(1)) w_state_d = StParity;
        end
      end
      StParity: begin
        if (!i_pkt_valid) begin
          w_trunc   = 1'b1;
          w_state_d = StIdle;
        end else if (w_accept) begin
          w_wr      = 1'b1;
          w_state_d = StCheck;
        end
      end
      StCheck: begin
        w_par_err = (r_par_acc != r_recv_par);
        w_state_d = StIdle;
      end
      StDrop: begin
        if (!i_pkt_valid) begin
          w_trunc   = 1'b1;
          w_state_d = StIdle;
        end else if (w_accept && r_len == '0) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // FSM state and per-packet context (dest, remaining length, parity).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= StIdle;
      r_dest     <= '0;
      r_len      <= '0;
      r_par_acc  <= '0;
      r_recv_par <= '0;
    end else begin
      r_state <= w_state_d;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_dest    <= w_hdr_dest;
            r_len     <= w_hdr_len;
            r_par_acc <= i_din;
          end
        end
        StPayload: begin
          if (w_accept) begin
            r_par_acc <= r_par_acc ^ i_din;
            r_len     <= r_len - 1'b1;
          end
        end
        StParity: begin
          if (w_accept) r_recv_par <= i_din;
        end
        StDrop: begin
          if (w_accept && r_len != '0) r_len <= r_len - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_err_sum = {1'b0, r_err_cnt} + 9'(w_par_err) + 9'(w_trunc);

  // Sticky saturating error counter.
  always_ff @(posedge clk) begin
    if (!resetn) r_err_cnt <= '0;
    else         r_err_cnt <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] w_count;
    logic [TW-1:0] r_tmr;

    router_fifo_param #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (w_push[i]),
      .i_wdata (i_din),
      .i_pop   (i_rd_en[i]),
      .i_flush (w_flush[i]),
      .o_dout  (o_dout[i*DW +: DW]),
      .o_count (w_count),
      .o_full  (w_full[i]),
      .o_empty (w_empty[i])
    );

    assign w_push[i]   = w_wr && (w_cur_dest == ADDR_W'(i));
    assign w_flush[i]  = (r_tmr == TW'(TIMEOUT));
    assign o_vldout[i] = (w_count != '0);

    // Idle-read timer: counts unread cycles on a non-empty channel.
    always_ff @(posedge clk) begin
      if (!resetn)                                  r_tmr <= '0;
      else if (w_empty[i] || i_rd_en[i] || w_flush[i]) r_tmr <= '0;
      else                                          r_tmr <= r_tmr + 1'b1;
    end
  end

  assign o_busy      = w_busy;
  assign o_err_par   = w_par_err;
  assign o_err_trunc = w_trunc;
  assign o_flush     = w_flush;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_pkt_router_param.sv
// Bench for pkt_router_param: directed scenarios followed by randomized
// traffic scored against per-channel byte queues.
module tb_pkt_router_param;

  localparam int unsigned DW      = 8;
  localparam int unsigned NCH     = 3;
  localparam int unsigned DEPTH   = 8;   // holds a 5-byte packet; back-pressure after 8 bytes
  localparam int unsigned TIMEOUT = 30;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              pkt_valid = 1'b0;
  logic [DW-1:0]     din = '0;
  logic [NCH-1:0]    rd_en = '0;
  logic              busy;
  logic [NCH*DW-1:0] dout;
  logic [NCH-1:0]    vldout;
  logic              err_par;
  logic              err_trunc;
  logic [NCH-1:0]    flush;
  logic [7:0]        err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pkt_router_param #(
    .DW      (DW),
    .NCH     (NCH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .i_pkt_valid (pkt_valid),
    .i_din       (din),
    .o_busy      (busy),
    .i_rd_en     (rd_en),
    .o_dout      (dout),
    .o_vldout    (vldout),
    .o_err_par   (err_par),
    .o_err_trunc (err_trunc),
    .o_flush     (flush),
    .o_err_cnt   (err_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] ch_dout(input int ch);
    return dout[ch*DW +: DW];
  endfunction

  // Drive one byte and hold it until accepted (bounded).
  task automatic send_byte(input logic [DW-1:0] b);
    int n;
    n = 0;
    pkt_valid = 1'b1;
    din       = b;
    #1;
    while (busy && n < 50) begin
      step();
      #1;
      n++;
    end
    if (busy) check_eq("send_stall", 32'(busy), 32'd0);
    step();
  endtask

  task automatic send_bytes(input logic [DW-1:0] bq[$]);
    foreach (bq[k]) send_byte(bq[k]);
  endtask

  task automatic pop_check(input string tag, input int ch, input logic [DW-1:0] exp);
    check_eq(tag, 32'(ch_dout(ch)), 32'(exp));
    rd_en[ch] = 1'b1;
    step();
    rd_en[ch] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] pk[$];
    logic [DW-1:0] par;
    logic [DW-1:0] mq[NCH][$];
    int            idle_cnt[NCH];
    int            n;
    int            d, l, keep, gap, pk_dest;
    logic          pk_wr, stop, fast, acc, rd, tr, bad;
    int            exp_par, exp_trunc, seen_par, seen_trunc, seen_flush, tot;

    // ---------------- reset ----------------
    resetn = 1'b0;
    repeat (3) step();
    resetn = 1'b1;
    step();
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_vld", 32'(vldout), 0);
    check_eq("rst_dout", 32'(dout), 0);
    check_eq("rst_flush", 32'(flush), 0);
    check_eq("rst_errcnt", 32'(err_cnt), 0);
    check_eq("rst_errs", 32'({err_par, err_trunc}), 0);

    // ---------------- good packet to ch0 ----------------
    pk = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
    send_bytes(pk);
    check_eq("good_busy_chk", 32'(busy), 1);
    check_eq("good_errpar", 32'(err_par), 0);
    pkt_valid = 1'b0;
    step();
    check_eq("good_vld", 32'(vldout), 32'b001);
    check_eq("good_errcnt", 32'(err_cnt), 0);
    foreach (pk[k]) pop_check("good_pop", 0, pk[k]);
    check_eq("good_empty", 32'(vldout), 0);

    // ---------------- bad parity ----------------
    pk = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'hFF};
    send_bytes(pk);
    check_eq("bad_errpar", 32'(err_par), 1);
    pkt_valid = 1'b0;
    step();
    check_eq("bad_errpar_pulse", 32'(err_par), 0);
    check_eq("bad_errcnt", 32'(err_cnt), 1);
    foreach (pk[k]) pop_check("bad_pop", 0, pk[k]);
    check_eq("bad_empty", 32'(vldout), 0);

    // ---------------- back-pressure on ch1: dest1, len9 ----------------
    par = 8'h25;
    send_byte(8'h25);
    for (int j = 1; j <= 7; j++) begin
      send_byte(DW'(j));
      par ^= DW'(j);
    end
    pkt_valid = 1'b1;
    din = 8'h08;
    #1;
    check_eq("bp_busy_full", 32'(busy), 1);
    step();
    #1;
    check_eq("bp_hold", 32'(busy), 1);
    rd_en[1] = 1'b1;
    step();
    rd_en[1] = 1'b0;
    #1;
    check_eq("bp_space", 32'(busy), 0);
    step();
    par ^= 8'h08;
    din = 8'h09;
    #1;
    check_eq("bp_one_more", 32'(busy), 1);
    rd_en[1] = 1'b1;
    send_byte(8'h09);
    par ^= 8'h09;
    send_byte(par);
    check_eq("bp_errpar", 32'(err_par), 0);
    pkt_valid = 1'b0;
    n = 0;
    while (vldout[1] && n < 20) begin
      step();
      n++;
    end
    rd_en = '0;
    check_eq("bp_drained", 32'(vldout), 0);
    check_eq("bp_errcnt", 32'(err_cnt), 1);

    // ---------------- invalid dest, then normal packet ----------------
    pkt_valid = 1'b1;
    din = 8'h07;
    #1;
    check_eq("drop_busy", 32'(busy), 0);
    pk = '{8'h07, 8'hA1, 8'hA2};
    send_bytes(pk);
    pkt_valid = 1'b0;
    #1;
    check_eq("drop_trunc", 32'(err_trunc), 0);
    check_eq("drop_vld", 32'(vldout), 0);
    check_eq("drop_errcnt", 32'(err_cnt), 1);
    pk = '{8'h0A, 8'hAA, 8'hBB, 8'h0A ^ 8'hAA ^ 8'hBB};
    send_bytes(pk);
    check_eq("post_drop_errpar", 32'(err_par), 0);
    pkt_valid = 1'b0;
    step();
    check_eq("post_drop_vld", 32'(vldout), 32'b100);
    foreach (pk[k]) pop_check("post_drop_pop", 2, pk[k]);

    // ---------------- truncation ----------------
    pk = '{8'h0E, 8'h5A};
    send_bytes(pk);
    pkt_valid = 1'b0;
    #1;
    check_eq("trunc_pulse", 32'(err_trunc), 1);
    step();
    check_eq("trunc_pulse_end", 32'(err_trunc), 0);
    check_eq("trunc_errcnt", 32'(err_cnt), 2);
    check_eq("trunc_vld", 32'(vldout), 32'b100);
    check_eq("trunc_busy", 32'(busy), 0);
    foreach (pk[k]) pop_check("trunc_pop", 2, pk[k]);
    check_eq("trunc_empty", 32'(vldout), 0);

    // ---------------- timeout flush on ch0 ----------------
    // Header written at edge E0, parity at E1; the timer reads k after Ek and the
    // flush pulse shows after E(TIMEOUT), i.e. TIMEOUT-1 cycles past this point.
    pk = '{8'h00, 8'h00};
    send_bytes(pk);
    pkt_valid = 1'b0;
    n = 0;
    while (!flush[0] && n < TIMEOUT + 10) begin
      step();
      n++;
    end
    check_eq("to_flush", 32'(flush), 32'b001);
    check_eq("to_cycles", 32'(n), TIMEOUT - 1);
    step();
    check_eq("to_vld", 32'(vldout), 0);
    check_eq("to_flush_end", 32'(flush), 0);

    // ---------------- reset mid-packet ----------------
    pk = '{8'h0C, 8'h11};
    send_bytes(pk);
    resetn = 1'b0;
    pkt_valid = 1'b0;
    step();
    resetn = 1'b1;
    #1;
    check_eq("mid_rst_vld", 32'(vldout), 0);
    check_eq("mid_rst_dout", 32'(dout), 0);
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_errcnt", 32'(err_cnt), 0);
    check_eq("mid_rst_errs", 32'({err_par, err_trunc}), 0);
    check_eq("mid_rst_flush", 32'(flush), 0);
    step();

    // ---------------- randomized traffic ----------------
    exp_par = 0; exp_trunc = 0; seen_par = 0; seen_trunc = 0; seen_flush = 0;
    gap = 0; pk_dest = 0; pk_wr = 1'b0;
    pk.delete();
    for (int c = 0; c < NCH; c++) idle_cnt[c] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      stop = (cyc >= 3000);
      fast = (((cyc / 200) % 2) == 0);
      for (int c = 0; c < NCH; c++) begin
        check_eq($sformatf("rnd_vld%0d", c), 32'(vldout[c]), 32'(mq[c].size() != 0));
        check_eq($sformatf("rnd_dout%0d", c), 32'(ch_dout(c)),
                 32'((mq[c].size() != 0) ? mq[c][0] : '0));
      end
      if (pk.size() == 0) begin
        if (gap > 0) gap--;
        else if (!stop) begin
          d = $urandom_range(0, 3);
          l = $urandom_range(0, 6);
          par = DW'((l << 2) | d);
          pk.push_back(par);
          for (int j = 0; j < l; j++) begin
            pk.push_back(DW'($urandom));
            par ^= pk[pk.size() - 1];
          end
          tr  = ($urandom_range(0, 7) == 0);
          bad = ($urandom_range(0, 3) == 0);
          if (tr) begin
            keep = $urandom_range(1, l + 1);
            while (pk.size() > keep) pk.pop_back();
            exp_trunc++;
          end else begin
            if (bad) par ^= DW'($urandom_range(1, 255));
            pk.push_back(par);
            if (bad && d < NCH) exp_par++;
          end
          pk_wr   = (d < NCH);
          pk_dest = d;
          gap     = $urandom_range(1, 3);
        end
      end
      pkt_valid = (pk.size() != 0);
      din       = (pk.size() != 0) ? pk[0] : '0;
      for (int c = 0; c < NCH; c++) begin
        if (stop)      rd = 1'b1;
        else if (fast) rd = ($urandom_range(0, 3) != 0);
        else           rd = ($urandom_range(0, 3) == 0);
        // Keep channels from going stale so the timeout never fires here.
        if (idle_cnt[c] >= TIMEOUT / 2) rd = 1'b1;
        rd_en[c] = rd;
      end
      #1;
      if (err_par)   seen_par++;
      if (err_trunc) seen_trunc++;
      if (flush != '0) seen_flush++;
      acc = pkt_valid && !busy;
      for (int c = 0; c < NCH; c++) begin
        if (mq[c].size() != 0 && !rd_en[c]) idle_cnt[c]++;
        else                                idle_cnt[c] = 0;
        if (rd_en[c] && mq[c].size() != 0) void'(mq[c].pop_front());
      end
      if (acc) begin
        if (pk_wr) mq[pk_dest].push_back(pk[0]);
        void'(pk.pop_front());
      end
      step();
    end
    pkt_valid = 1'b0;
    rd_en = '0;
    #1;
    tot = exp_par + exp_trunc;
    if (tot > 255) tot = 255;
    check_eq("rnd_final_vld", 32'(vldout), 0);
    check_eq("rnd_par_pulses", 32'(seen_par), 32'(exp_par));
    check_eq("rnd_trunc_pulses", 32'(seen_trunc), 32'(exp_trunc));
    check_eq("rnd_flushes", 32'(seen_flush), 0);
    check_eq("rnd_errcnt", 32'(err_cnt), 32'(tot));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
